// File: rtl/acc_alu_sequencer.sv
// rtl/acc_alu_sequencer.sv - T-state control sequencer for the accumulator/ALU datapath
// Optional single-step gating of EX1/EX2 is compiled in with ACC_SEQ_STEP_EN.
module acc_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ACC_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] opnd_out,
  output logic             ei,
  output logic             ea,
  output logic             eu,
  output logic             sub,
  output logic             lb,
  output logic             nla,
  output logic             lo,
  input  logic             alu_cf,
  input  logic             alu_zf,
  output logic             cf,
  output logic             zf,
  output logic             done,
  output logic             halted,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, EX1, EX2, DONE, HALT} state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OUT = 3'd4;
  localparam logic [2:0] OP_HLT = 3'd5;

  state_t     state, state_n;
  logic [2:0] op_q, op_n;
  logic       accept, illegal, advance;
  logic       ei_n, ea_n, eu_n, sub_n, lb_n, nla_n, lo_n;

`ifdef ACC_SEQ_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign accept  = (state == IDLE) && cmd_valid;
  assign illegal = cmd_op[2] & cmd_op[1];
  assign op_n    = accept ? cmd_op : op_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = (cmd_op == OP_NOP || illegal) ? DONE : EX1;
      EX1: begin
        if (advance) begin
          case (op_q)
            OP_ADD, OP_SUB: state_n = EX2;
            OP_HLT:         state_n = HALT;
            default:        state_n = DONE;
          endcase
        end
      end
      EX2:     if (advance) state_n = DONE;
      DONE:    state_n = IDLE;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are decoded one cycle early so they leave the flops as clean Moore outputs.
  always_comb begin
    ei_n  = 1'b0;
    ea_n  = 1'b0;
    eu_n  = 1'b0;
    sub_n = 1'b0;
    lb_n  = 1'b0;
    nla_n = 1'b1;
    lo_n  = 1'b0;
    case (state_n)
      EX1: begin
        case (op_n)
          OP_LDA: begin
            ei_n  = 1'b1;
            nla_n = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            ei_n = 1'b1;
            lb_n = 1'b1;
          end
          OP_OUT: begin
            ea_n = 1'b1;
            lo_n = 1'b1;
          end
          default: ;
        endcase
      end
      EX2: begin
        eu_n  = 1'b1;
        nla_n = 1'b0;
        sub_n = (op_n == OP_SUB);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      cmd_ready <= 1'b1;
      opnd_out  <= '0;
      ei        <= 1'b0;
      ea        <= 1'b0;
      eu        <= 1'b0;
      sub       <= 1'b0;
      lb        <= 1'b0;
      nla       <= 1'b1;
      lo        <= 1'b0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      cmd_ready <= (state_n == IDLE);
      done      <= (state_n == DONE);
      halted    <= (state_n == HALT);
      ei        <= ei_n;
      ea        <= ea_n;
      eu        <= eu_n;
      sub       <= sub_n;
      lb        <= lb_n;
      nla       <= nla_n;
      lo        <= lo_n;
      if (accept) begin
        opnd_out <= cmd_data;
        if (illegal) err <= 1'b1;
      end
      // Flags follow the ALU only on the cycle the result is written back.
      if (state == EX2 && advance) begin
        cf <= alu_cf;
        zf <= alu_zf;
      end
    end
  end

endmodule

// File: doc/acc_alu_sequencer.md
Name: acc_alu_sequencer

Overview:
- Control unit for the accumulator/ALU datapath; owns the 8-bit shared bus.
- Accepts one command at a time through a valid/ready handshake and steps it through T-states.
- Drives the bus-enable and load strobes for the operand driver, B register, ALU, accumulator and output register.
- Registers the ALU carry and zero flags for the rest of the design.

Parameters:
- WIDTH, 8, datapath/bus width; sets the widths of cmd_data and opnd_out.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  3  opcode: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 OUT, 5 HLT, 6/7 illegal
- cmd_data  input  WIDTH  immediate operand
- opnd_out  output  WIDTH  latched operand; driven onto the bus when ei=1
- ei  output  1  operand driver enable onto bus
- ea  output  1  accumulator drives bus
- eu  output  1  ALU result drives bus
- sub  output  1  ALU subtract select
- lb  output  1  load B register from bus
- nla  output  1  load accumulator from bus, active low
- lo  output  1  load output register from bus
- alu_cf  input  1  ALU carry out
- alu_zf  input  1  ALU zero
- cf  output  1  registered carry flag
- zf  output  1  registered zero flag
- done  output  1  one-cycle pulse when a command retires
- halted  output  1  HLT executed
- err  output  1  sticky: illegal opcode seen

Behaviour:
- Reset (async):
  - state=IDLE, cmd_ready=1.
  - ei=ea=eu=sub=lb=lo=0, nla=1.
  - opnd_out=0, cf=zf=0, done=0, halted=0, err=0.
  - Reset applied mid-command aborts it with no partial strobe.
- States: IDLE, EX1, EX2, DONE, HALT.
- Outputs: all strobes are Moore outputs decoded from the state and the latched opcode; no strobe depends combinationally on cmd_* inputs.
- IDLE:
  - cmd_ready=1.
  - Accept on the edge where cmd_valid & cmd_ready are both 1: latch op and data (opnd_out <= cmd_data).
  - Next state: EX1; for NOP or illegal opcodes go directly to DONE.
  - Illegal opcode also sets err (sticky until reset).
- EX1:
  - LDA: ei=1, nla=0 -> DONE.
  - ADD/SUB: ei=1, lb=1 -> EX2.
  - OUT: ea=1, lo=1 -> DONE.
  - HLT: no strobes -> HALT.
- EX2 (ADD/SUB only):
  - eu=1, nla=0; sub=1 for SUB, 0 for ADD.
  - At the end of the cycle: cf<=alu_cf, zf<=alu_zf -> DONE.
  - Flags update only here; LDA, OUT and NOP leave cf/zf unchanged.
- DONE: done=1 for exactly one cycle, cmd_ready=0 -> IDLE.
- HALT:
  - halted=1, cmd_ready=0, all strobes inactive.
  - cmd_valid is ignored; only rst_n exits.
- Latency, counted from the accept edge (cycle 0):
  - LDA/OUT: done in cycle 2, cmd_ready=1 in cycle 3.
  - ADD/SUB: done in cycle 3, cmd_ready=1 in cycle 4.
  - NOP/illegal: done in cycle 1.
- Throughput: one command per 3–4 cycles; cmd_ready is low during EX1/EX2/DONE.
- Invariant: at most one of ei, ea, eu is high in any cycle (no bus contention).
- Invariant: nla=0 and lb=1 never occur together.
- Handshake: cmd_op/cmd_data may change freely while cmd_ready=0 or cmd_valid=0; a command held valid across DONE is accepted exactly once per IDLE cycle.

Optional Feature:
- Macro: ACC_SEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - Transitions out of EX1 and EX2 occur only in a cycle where step=1; strobes stay asserted while waiting.
  - Flags latch only on the advancing EX2 cycle.
  - IDLE accept and DONE are unaffected.
- Undefined: no step port; EX1/EX2 always advance after one cycle.

Test Plan:
- Reset: hold rst_n=0 during EX2 of a SUB -> all strobes inactive immediately, nla=1, cf=zf=0, cmd_ready=1 after release.
- LDA then OUT:
  - LDA 0x2A -> EX1 has ei=1, nla=0, opnd_out=0x2A, done in cycle 2.
  - OUT -> EX1 has ea=1, lo=1, no flag change.
- ADD with carry:
  - Model ALU: LDA 0xF0, ADD 0x20 -> EX1 lb=1/ei=1, EX2 eu=1/sub=0/nla=0; cf=1, zf=0 after EX2; done in cycle 3.
  - SUB to zero: LDA 0x05, SUB 0x05 -> sub=1 in EX2, zf=1.
- Back-to-back: cmd_valid held high with 3 ADDs -> exactly 3 done pulses, one accept per IDLE cycle, ei/ea/eu never overlap (assertion).
- Illegal and halt:
  - op=6 -> done in cycle 1, err=1 sticky, no strobes.
  - HLT -> halted=1, cmd_ready=0; further cmd_valid ignored until rst_n.
- Step mode (ACC_SEQ_STEP_EN): ADD with step=0 for 5 cycles in EX1 -> lb/ei held, no advance; step=1 -> EX2; flags latch only on the stepping cycle.
